nor_2: RTL and testbench
========================

Name: nor_2

Overview:
- 2-input bitwise NOR gate. The primary output c is purely combinational and valid even when no clock is running.
- A clocked side-path adds:
  - a registered copy of the result,
  - a rising-edge pulse,
  - a cycle counter for how long the result is high,
  - truth-table coverage flags for the 4 input combinations.
- Used as a basic logic primitive in lab designs and as a self-checking gate for bring-up.

Parameters:
- WIDTH, 1: bit width of a, b, c (bitwise NOR per bit).
- CNT_W, 16: width of the high-cycle counter.

Ports:
- clk  input  1  system clock; all registers update on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- clr  input  1  synchronous clear of counter and coverage flags; active high.
- c  output  WIDTH  combinational result, c = ~(a | b), bitwise.
- c_q  output  WIDTH  c registered one clock later.
- c_rise  output  1  one-cycle pulse when c[0] goes 0->1 (compared against c_q[0]).
- high_cnt  output  CNT_W  number of clock cycles in which c[0] was sampled 1.
- combo_seen  output  4  sticky flags; bit i set once {a[0],b[0]}==i has been sampled on a clock edge.
- all_seen  output  1  high when combo_seen == 4'b1111.

Behaviour:
- c:
  - Combinational, zero latency.
  - Independent of clk, rst_n and clr; a bench with clk tied low and rst_n undriven must still see a correct c.
  - Truth table per bit: 00->1, 01->0, 10->0, 11->0.
- Reset (rst_n=0, asynchronous, takes effect immediately without a clock edge):
  - c_q = 0, c_rise = 0, high_cnt = 0, combo_seen = 0, all_seen = 0.
  - c keeps following a, b during reset.
- Reset release: registers resume on the first rising clk edge with rst_n=1. No other reset synchronisation is performed inside the block.
- c_q: updates to the current value of c on every rising edge; latency 1 cycle.
- c_rise:
  - Registered: c_rise <= c[0] & ~c_q[0].
  - High for exactly one cycle per 0->1 transition of the sampled c[0].
  - After reset, c[0]=1 on the first edge counts as a rise.
- high_cnt:
  - Increments by 1 on each edge where c[0]=1.
  - Saturates at 2^CNT_W-1; no wrap.
- combo_seen:
  - On each edge, sets bit {a[0],b[0]}; bits are sticky.
  - Only reset or clr clears them.
- all_seen: combinational AND of the combo_seen bits.
- clr:
  - On an edge with clr=1, high_cnt and combo_seen go to 0.
  - That edge's sample is not counted or flagged; clr has priority.
  - c_q and c_rise still update normally.
- X/Z on inputs: no special handling; propagates per standard Verilog semantics.
- No handshake; no state machine beyond the registers above.

Test Plan:
- No clock, rst_n held 0. Apply a,b = 00,01,10,11, holding each for 100 ns -> c = 1,0,0,0, settled within the same timestep.
- Reset, then clock 4 cycles with a,b = 00,01,10,11:
  - c_q lags c by one cycle: 1,0,0,0.
  - high_cnt = 1.
  - combo_seen = 4'b1111, all_seen = 1.
- Sequence a,b = 01 -> 00 -> 00 -> 11 -> 00, one value per cycle -> c_rise pulses exactly once after each 0->1 of c (2 pulses total), each pulse 1 cycle wide.
- With CNT_W=4, hold a=b=0 for 20 cycles -> high_cnt reaches 15 and stays at 15.
- Mid-run, assert rst_n=0 between clock edges -> all registered outputs are 0 immediately; c still tracks the inputs. Assert clr=1 with a=b=0 for one edge -> high_cnt=0, combo_seen=0 after that edge.
- WIDTH=4, a=4'b1010, b=4'b0110 -> c=4'b0001; after the next edge, c_q=4'b0001.

Source files
------------

// File: rtl/nor_2.sv
// Bitwise 2-input NOR with a clocked observation side-path: registered copy, rise pulse,
// saturating high-cycle counter and sticky input-combination coverage flags.
module nor_2 #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             c_rise,
  output logic [CNT_W-1:0] high_cnt,
  output logic [3:0]       combo_seen,
  output logic             all_seen
);

  logic [CNT_W-1:0] high_cnt_d;
  logic [3:0]       combo_seen_d;
  logic [1:0]       combo_idx;

  // Primary result stays purely combinational so it works with no clock or reset.
  assign c         = ~(a | b);
  assign combo_idx = {a[0], b[0]};
  assign all_seen  = &combo_seen;

  always_comb begin
    high_cnt_d   = high_cnt;
    combo_seen_d = combo_seen;
    if (clr) begin
      // Clear wins over this edge's sample.
      high_cnt_d   = '0;
      combo_seen_d = '0;
    end else begin
      if (c[0] && (high_cnt != {CNT_W{1'b1}})) begin
        high_cnt_d = high_cnt + CNT_W'(1);
      end
      combo_seen_d = combo_seen | (4'b0001 << combo_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q        <= '0;
      c_rise     <= 1'b0;
      high_cnt   <= '0;
      combo_seen <= '0;
    end else begin
      c_q        <= c;
      c_rise     <= c[0] & ~c_q[0];
      high_cnt   <= high_cnt_d;
      combo_seen <= combo_seen_d;
    end
  end

endmodule

// File: tb/tb_nor_2.sv
// Directed, table-driven bench for nor_2 (WIDTH=4, CNT_W=4 so saturation is reachable).
module tb_nor_2;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          run_clk;
  logic          rst_n;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          clr;
  logic [W-1:0]  c;
  logic [W-1:0]  c_q;
  logic          c_rise;
  logic [CW-1:0] high_cnt;
  logic [3:0]    combo_seen;
  logic          all_seen;

  int tests;
  int fails;

  nor_2 #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .clr       (clr),
    .c         (c),
    .c_q       (c_q),
    .c_rise    (c_rise),
    .high_cnt  (high_cnt),
    .combo_seen(combo_seen),
    .all_seen  (all_seen)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (run_clk) clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } comb_vec_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          clr;
    logic [W-1:0]  c_q;
    logic          rise;
    logic [CW-1:0] cnt;
    logic [3:0]    combo;
    logic          all;
  } seq_vec_t;

  comb_vec_t cv[6];
  seq_vec_t  sv[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, " c_q"}, 32'(c_q), 32'd0);
    check({tag, " c_rise"}, 32'(c_rise), 32'd0);
    check({tag, " high_cnt"}, 32'(high_cnt), 32'd0);
    check({tag, " combo_seen"}, 32'(combo_seen), 32'd0);
    check({tag, " all_seen"}, 32'(all_seen), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests   = 0;
    fails   = 0;
    run_clk = 1'b0;
    rst_n   = 1'b0;
    clr     = 1'b0;
    a       = '0;
    b       = '0;

    // Combinational vectors: {a, b, c}
    cv[0] = '{4'b0000, 4'b0000, 4'b1111};
    cv[1] = '{4'b0000, 4'b0001, 4'b1110};
    cv[2] = '{4'b0001, 4'b0000, 4'b1110};
    cv[3] = '{4'b1111, 4'b1111, 4'b0000};
    cv[4] = '{4'b1100, 4'b0011, 4'b0000};
    cv[5] = '{4'b1010, 4'b0110, 4'b0001};

    // Clocked vectors: inputs, then expected values right after the edge.
    sv[0]  = '{4'h0, 4'h0, 1'b0, 4'hF, 1'b1, 4'd1, 4'b0001, 1'b0};
    sv[1]  = '{4'h0, 4'h1, 1'b0, 4'hE, 1'b0, 4'd1, 4'b0011, 1'b0};
    sv[2]  = '{4'h1, 4'h0, 1'b0, 4'hE, 1'b0, 4'd1, 4'b0111, 1'b0};
    sv[3]  = '{4'h1, 4'h1, 1'b0, 4'hE, 1'b0, 4'd1, 4'b1111, 1'b1};
    sv[4]  = '{4'h0, 4'h1, 1'b0, 4'hE, 1'b0, 4'd1, 4'b1111, 1'b1};
    sv[5]  = '{4'h0, 4'h0, 1'b0, 4'hF, 1'b1, 4'd2, 4'b1111, 1'b1};
    sv[6]  = '{4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 4'd3, 4'b1111, 1'b1};
    sv[7]  = '{4'h1, 4'h1, 1'b0, 4'hE, 1'b0, 4'd3, 4'b1111, 1'b1};
    sv[8]  = '{4'h0, 4'h0, 1'b0, 4'hF, 1'b1, 4'd4, 4'b1111, 1'b1};
    sv[9]  = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 4'd0, 4'b0000, 1'b0};
    sv[10] = '{4'h1, 4'h0, 1'b0, 4'hE, 1'b0, 4'd0, 4'b0100, 1'b0};
    sv[11] = '{4'h1, 4'h1, 1'b1, 4'hE, 1'b0, 4'd0, 4'b0000, 1'b0};

    // No clock, reset held: c must still follow the inputs.
    #1;
    check_regs_zero("reset");
    for (int i = 0; i < 6; i++) begin
      a = cv[i].a;
      b = cv[i].b;
      #1;
      check($sformatf("comb c[%0d]", i), 32'(c), 32'(cv[i].c));
      #99;
    end

    a       = '0;
    b       = '0;
    rst_n   = 1'b1;
    run_clk = 1'b1;

    for (int i = 0; i < 12; i++) begin
      a   = sv[i].a;
      b   = sv[i].b;
      clr = sv[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("seq c_q[%0d]", i), 32'(c_q), 32'(sv[i].c_q));
      check($sformatf("seq c_rise[%0d]", i), 32'(c_rise), 32'(sv[i].rise));
      check($sformatf("seq high_cnt[%0d]", i), 32'(high_cnt), 32'(sv[i].cnt));
      check($sformatf("seq combo_seen[%0d]", i), 32'(combo_seen), 32'(sv[i].combo));
      check($sformatf("seq all_seen[%0d]", i), 32'(all_seen), 32'(sv[i].all));
    end
    clr = 1'b0;

    // Saturation: counter starts at 0 here, c[0]=1 every cycle.
    a = '0;
    b = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat high_cnt[%0d]", i), 32'(high_cnt), (i > 15) ? 32'd15 : 32'(i));
      check($sformatf("sat c_rise[%0d]", i), 32'(c_rise), (i == 1) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_regs_zero("async reset");
    a = 4'b0101;
    b = 4'b0000;
    #1;
    check("c during reset", 32'(c), 32'h0000000A);
    a = '0;
    #1;
    check("c during reset 2", 32'(c), 32'h0000000F);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset c_rise", 32'(c_rise), 32'd1);
    check("post-reset high_cnt", 32'(high_cnt), 32'd1);
    check("post-reset combo_seen", 32'(combo_seen), 32'b0001);
    check("post-reset c_q", 32'(c_q), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
